// File: rtl/pipelined_adder_n_if.sv
// Handshake bundle for pipelined_adder_n: operand side (in_*) and result side (out_*).
// Optional feature macro: ADDER_OVF_EN adds the signed-overflow signal ovf.
interface pipelined_adder_n_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    // Operand producer and result consumer side.
    modport master (
        output in_valid, in1, in2, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , input ovf
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, in1, in2, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_adder_n.sv
// Pipelined ripple-chunk adder: WIDTH-bit add split into WIDTH/CHUNK register stages,
// one CHUNK-bit slice per stage, carry registered between stages. Global-stall
// valid/ready pipeline with one result per cycle and latency WIDTH/CHUNK.
// Optional feature macro: ADDER_OVF_EN adds a registered signed-overflow output ovf.
module pipelined_adder_n #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_n_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    if ((STAGES < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
        $error("pipelined_adder_n: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
               WIDTH, CHUNK);
    end

    // Whole pipeline moves together whenever the output slot is free or being drained.
    logic adv;
    logic out_valid;

    // Values entering stage k: operands, partial sum, carry and valid bit.
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    assign adv           = !out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;

    assign a_in[0] = bus.in1;
    assign b_in[0] = bus.in2;
    assign s_in[0] = '0;
    assign c_in[0] = bus.cin;
    assign v_in[0] = bus.in_valid && adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   chunk_sum;
        logic [WIDTH-1:0] s_d;
        logic             c_d;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        // Add slice k plus incoming carry and splice it into the partial sum.
        always_comb begin
            // NOTE: s_d takes a full default before the slice overwrite, so no latch is inferred;
            // combinational logic uses blocking assignments.
            s_d       = s_in[k];
            chunk_sum = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                      + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, c_in[k]};
            s_d[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
            c_d       = chunk_sum[CHUNK];
        end

        // Stage result register: loads on advance, holds under stall.
        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples
            // its predecessor's pre-edge value.
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_in[k];
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Carry the operands forward until their upper slices have been consumed.
            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: operand registers are cleared on reset too, so nothing from before
                // reset can leak into a later result.
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[k];
                    b_q <= b_in[k];
                end
            end

            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
            assign s_in[k+1] = s_q;
            assign c_in[k+1] = c_q;
            assign v_in[k+1] = v_q;
        end else begin : g_last
            // Lower operand slices are already consumed by earlier stages here.
            logic unused_ops;
            assign unused_ops = ^{a_in[k], b_in[k]};

            assign out_valid = v_q;
            assign bus.sum   = s_q;
            assign bus.cout  = c_q;

`ifdef ADDER_OVF_EN
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB is a^b^s at that bit; overflow when it differs from carry out.
            assign ovf_d = a_in[k][WIDTH-1] ^ b_in[k][WIDTH-1] ^ s_d[WIDTH-1] ^ c_d;

            // Overflow flag travels with the final sum register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign bus.ovf = ovf_q;
`endif
        end
    end
endmodule

// File: tb/tb_pipelined_adder_n.sv
// Self-checking bench for pipelined_adder_n: directed tests on a 32/8 instance and
// randomized handshake traffic on 16/4 and 8/8 instances against an arithmetic model.
// Optional feature macro: ADDER_OVF_EN enables the ovf checks.
module tb_pipelined_adder_n;
    localparam int N_RAND      = 10000;
    localparam int RAND_BUDGET = 60000;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_go  = 1'b0;
    bit   rand_done [2];

    always #5 clk = ~clk;

    pipelined_adder_n_if #(.WIDTH(32)) bus32 ();
    pipelined_adder_n #(.WIDTH(32), .CHUNK(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    logic [31:0] op_a [8];
    logic [31:0] op_b [8];
    logic        op_c [8];
    logic [32:0] exp_r [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_add32(input logic [31:0] a, input logic [31:0] b,
                                               input logic c);
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    function automatic logic ref_ovf32(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    // One operation into an empty pipeline; checks latency and result.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic c);
        logic [32:0] e;
        int          lat;
        e = ref_add32(a, b, c);
        @(posedge clk); #1;
        bus32.in1 = a; bus32.in2 = b; bus32.cin = c;
        bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (bus32.out_valid) break;
            @(posedge clk);
            lat++;
        end
        check($sformatf("%s latency", tag), lat, 4);
        check($sformatf("%s sum", tag), {bus32.cout, bus32.sum}, e);
`ifdef ADDER_OVF_EN
        check($sformatf("%s ovf", tag), bus32.ovf, ref_ovf32(a, b, e[31:0]));
`endif
        @(posedge clk); #1;
    endtask

    // Back-to-back burst of n ops, optional output stall, then in-order collection.
    task automatic run_burst(input string tag, input int n, input int stall);
        int got_n;
        for (int i = 0; i < n; i++) exp_r[i] = ref_add32(op_a[i], op_b[i], op_c[i]);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus32.in1 = op_a[i]; bus32.in2 = op_b[i]; bus32.cin = op_c[i];
            bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        if (stall > 0) bus32.out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check($sformatf("%s stall%0d valid", tag, s), bus32.out_valid, 1'b1);
            check($sformatf("%s stall%0d in_ready", tag, s), bus32.in_ready, 1'b0);
            check($sformatf("%s stall%0d held", tag, s), {bus32.cout, bus32.sum}, exp_r[0]);
            @(posedge clk); #1;
        end
        bus32.out_ready = 1'b1;
        got_n = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus32.out_valid) begin
                if (got_n < n)
                    check($sformatf("%s result%0d", tag, got_n), {bus32.cout, bus32.sum},
                          exp_r[got_n]);
                check($sformatf("%s slot%0d", tag, got_n), cyc, got_n);
                got_n++;
            end
            @(posedge clk); #1;
        end
        check($sformatf("%s count", tag), got_n, n);
    endtask

    // Randomized traffic on narrower configurations.
    for (genvar g = 0; g < 2; g++) begin : g_rand
        localparam int W = (g == 0) ? 16 : 8;
        localparam int C = (g == 0) ? 4 : 8;

        pipelined_adder_n_if #(.WIDTH(W)) rbus ();
        pipelined_adder_n #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .rst_n(rst_n), .bus(rbus));

        initial begin : p_rand
            logic [W+1:0] exp_q [$];
            logic [W+1:0] e;
            logic [W:0]   full;
            logic [W:0]   held;
            logic         held_v;
            logic         ovf_ref;
            int           n_acc;
            int           n_done;
            int           cyc;
            rbus.in_valid  = 1'b0;
            rbus.in1       = '0;
            rbus.in2       = '0;
            rbus.cin       = 1'b0;
            rbus.out_ready = 1'b1;
            rand_done[g]   = 1'b0;
            n_acc = 0; n_done = 0; cyc = 0;
            held_v = 1'b0; held = '0;
            wait (rand_go);
            @(posedge clk); #1;
            while ((n_done < N_RAND) && (cyc < RAND_BUDGET)) begin
                @(negedge clk);
                cyc++;
                check($sformatf("w%0d in_ready", W), rbus.in_ready,
                      !rbus.out_valid || rbus.out_ready);
                if (held_v)
                    check($sformatf("w%0d hold", W), {rbus.out_valid, rbus.cout, rbus.sum},
                          {1'b1, held});
                if (rbus.out_valid && rbus.out_ready) begin
                    check($sformatf("w%0d pending", W), exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("w%0d result%0d", W, n_done), {rbus.cout, rbus.sum},
                              e[W:0]);
`ifdef ADDER_OVF_EN
                        check($sformatf("w%0d ovf%0d", W, n_done), rbus.ovf, e[W+1]);
`endif
                        n_done++;
                    end
                end
                held_v = rbus.out_valid && !rbus.out_ready;
                held   = {rbus.cout, rbus.sum};
                if (rbus.in_valid && rbus.in_ready) begin
                    full    = {1'b0, rbus.in1} + {1'b0, rbus.in2} + (W+1)'(rbus.cin);
                    ovf_ref = (rbus.in1[W-1] == rbus.in2[W-1]) && (full[W-1] != rbus.in1[W-1]);
                    e       = {ovf_ref, full};
                    exp_q.push_back(e);
                    n_acc++;
                end
                @(posedge clk); #1;
                rbus.in_valid  = (n_acc < N_RAND) && ($urandom_range(0, 9) < 7);
                rbus.in1       = W'($urandom);
                rbus.in2       = W'($urandom);
                rbus.cin       = 1'($urandom_range(0, 1));
                rbus.out_ready = ($urandom_range(0, 9) < 7);
            end
            rbus.in_valid = 1'b0;
            check($sformatf("w%0d accepted", W), n_acc, N_RAND);
            check($sformatf("w%0d delivered", W), n_done, N_RAND);
            check($sformatf("w%0d leftover", W), exp_q.size(), 0);
            rand_done[g] = 1'b1;
        end
    end

    initial begin : p_main
        bus32.in_valid  = 1'b0;
        bus32.in1       = '0;
        bus32.in2       = '0;
        bus32.cin       = 1'b0;
        bus32.out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        check("reset out_valid", bus32.out_valid, 1'b0);
        check("reset in_ready", bus32.in_ready, 1'b1);
        check("reset sum/cout", {bus32.cout, bus32.sum}, 33'd0);
`ifdef ADDER_OVF_EN
        check("reset ovf", bus32.ovf, 1'b0);
`endif
        #21 rst_n = 1'b1;

        // Full carry ripple through every stage.
        send_one("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send_one("cin ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

        // Four back-to-back ops, consumer always ready.
        op_a[0] = 32'h1234_5678; op_b[0] = 32'h1111_1111; op_c[0] = 1'b0;
        op_a[1] = 32'hFFFF_FFFF; op_b[1] = 32'h0000_0000; op_c[1] = 1'b1;
        op_a[2] = 32'h0000_FFFF; op_b[2] = 32'h0000_0001; op_c[2] = 1'b0;
        op_a[3] = 32'hA5A5_A5A5; op_b[3] = 32'h5A5A_5A5A; op_c[3] = 1'b1;
        run_burst("b2b", 4, 0);

        // Output stall for three cycles with results in flight.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = 1'($urandom_range(0, 1));
        end
        run_burst("stall", 4, 3);

        // Reset with three ops in flight: one already at the output.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus32.in1 = $urandom; bus32.in2 = $urandom; bus32.cin = 1'b1;
            bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre-reset out_valid", bus32.out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid reset out_valid", bus32.out_valid, 1'b0);
        check("mid reset sum/cout", {bus32.cout, bus32.sum}, 33'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (bus32.out_valid) stale++;
            end
            check("post-reset stale results", stale, 0);
        end
        send_one("post-reset", 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);

`ifdef ADDER_OVF_EN
        send_one("ovf pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send_one("ovf neg", 32'h8000_0000, 32'h8000_0000, 1'b0);
`endif

        // Randomized traffic on the narrower instances.
        rand_go = 1'b1;
        wait (rand_done[0] && rand_done[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
